// File: rtl/glcd_write_engine.sv
// -----------------------------------------------------------------------------
// glcd_write_engine
//
// Bus-level write engine for a dual-controller 128x64 graphic LCD (one
// controller per 64-column half, selected by cs1/cs2). After reset it pulses
// the panel reset, runs a four-command init on both halves, then accepts
// column-byte writes (page, column, data) over a valid/ready handshake. Each
// write is issued as up to three bus cycles: PAGE, COL and DATA. Every bus
// cycle holds cs1/cs2/lcd_rs/lcd_data stable for T_SU+T_EH+T_HD clocks, and
// lcd_e is high only for the middle T_EH clocks.
//
// Build option:
//   GLCD_ADDR_CACHE_EN  when defined, each half keeps a page/column cache, and
//                       PAGE/COL cycles that would not change the panel's
//                       address are skipped. When undefined, every write
//                       issues PAGE, COL and DATA.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   req_valid/req_ready   write request handshake
//   req_page[2:0]         target page 0..7
//   req_col[6:0]          target column 0..127 (bit 6 selects the half)
//   req_data[7:0]         column byte
//   init_done             panel init finished (held until reset)
//   lcd_rst_n             panel reset, active-low
//   cs1, cs2              half selects
//   lcd_rs, lcd_rw, lcd_e panel control (lcd_rw is always 0)
//   lcd_data[7:0]         panel data bus
// -----------------------------------------------------------------------------
module glcd_write_engine #(
  parameter int unsigned T_SU       = 2,
  parameter int unsigned T_EH       = 4,
  parameter int unsigned T_HD       = 2,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_page,
  input  logic [6:0] req_col,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       lcd_rst_n,
  output logic       cs1,
  output logic       cs2,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned BUS_LEN  = T_SU + T_EH + T_HD;
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] BUS_LAST = 16'(BUS_LEN - 1);
  localparam logic [15:0] E_ON     = 16'(T_SU);
  localparam logic [15:0] E_OFF    = 16'(T_SU + T_EH);

  localparam logic [2:0] ST_RST_LO = 3'd0;
  localparam logic [2:0] ST_RST_HI = 3'd1;
  localparam logic [2:0] ST_INIT   = 3'd2;
  localparam logic [2:0] ST_IDLE   = 3'd3;
  localparam logic [2:0] ST_PAGE   = 3'd4;
  localparam logic [2:0] ST_COL    = 3'd5;
  localparam logic [2:0] ST_DATA   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;          // reset-phase length or position inside a bus cycle
  logic [1:0]  init_idx_q, init_idx_d;
  logic [2:0]  page_q, page_d;
  logic [6:0]  col_q, col_d;
  logic [7:0]  data_q, data_d;

  logic cnt_last;
  logic in_bus;
  logic need_page_req;                // decided from the incoming request at accept
  logic need_col_req;
  logic need_col_lat;                 // decided from the latched request at end of PAGE

  assign cnt_last = (cnt_q == BUS_LAST);
  assign in_bus   = (state_q == ST_INIT) || (state_q == ST_PAGE) ||
                    (state_q == ST_COL)  || (state_q == ST_DATA);

`ifdef GLCD_ADDR_CACHE_EN
  // Per-half shadow of the panel's page register and Y counter.
  logic [2:0] cpage_q [2];
  logic [5:0] ccol_q  [2];
  logic [1:0] cvalid_q;
  logic       init_end;
  logic       data_end;

  assign init_end = (state_q == ST_INIT) && cnt_last && (init_idx_q == 2'd3);
  assign data_end = (state_q == ST_DATA) && cnt_last;

  assign need_page_req = !cvalid_q[req_col[6]] || (cpage_q[req_col[6]] != req_page);
  assign need_col_req  = !cvalid_q[req_col[6]] || (ccol_q[req_col[6]]  != req_col[5:0]);
  assign need_col_lat  = !cvalid_q[col_q[6]]   || (ccol_q[col_q[6]]    != col_q[5:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      cvalid_q <= '0;
    end else if (init_end) begin
      cvalid_q <= 2'b11;
    end else if (data_end) begin
      cvalid_q[col_q[6]] <= 1'b1;
    end
  end

  // NOTE: the cache contents carry no reset; the valid bits alone decide
  // whether they are trusted, which keeps reset fan-out off the storage.
  always_ff @(posedge clk) begin
    if (init_end) begin
      cpage_q[0] <= '0;
      cpage_q[1] <= '0;
      ccol_q[0]  <= '0;
      ccol_q[1]  <= '0;
    end else if (data_end) begin
      // Panel Y auto-increments after a data write and wraps 63 -> 0.
      cpage_q[col_q[6]] <= page_q;
      ccol_q[col_q[6]]  <= col_q[5:0] + 6'd1;
    end
  end
`else
  assign need_page_req = 1'b1;
  assign need_col_req  = 1'b1;
  assign need_col_lat  = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable takes a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    init_idx_d = init_idx_q;
    page_d     = page_q;
    col_d      = col_q;
    data_d     = data_q;
    case (state_q)
      ST_RST_LO: if (cnt_q == RST_LAST) begin
        state_d = ST_RST_HI;
        cnt_d   = '0;
      end
      ST_RST_HI: if (cnt_q == RST_LAST) begin
        state_d    = ST_INIT;
        cnt_d      = '0;
        init_idx_d = '0;
      end
      ST_INIT: if (cnt_last) begin
        cnt_d      = '0;
        init_idx_d = init_idx_q + 2'd1;
        if (init_idx_q == 2'd3) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          page_d  = req_page;
          col_d   = req_col;
          data_d  = req_data;
          state_d = need_page_req ? ST_PAGE : (need_col_req ? ST_COL : ST_DATA);
        end
      end
      ST_PAGE: if (cnt_last) begin
        cnt_d   = '0;
        state_d = need_col_lat ? ST_COL : ST_DATA;
      end
      ST_COL: if (cnt_last) begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (cnt_last) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q    <= ST_RST_LO;
      cnt_q      <= '0;
      init_idx_q <= '0;
      page_q     <= '0;
      col_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      page_q     <= page_d;
      col_q      <= col_d;
      data_q     <= data_d;
    end
  end

  // Outputs decode directly from registered state, so they change only on
  // clock edges and take their reset values on the edge that samples reset.
  always_comb begin
    cs1      = 1'b0;
    cs2      = 1'b0;
    lcd_rs   = 1'b0;
    lcd_data = '0;
    case (state_q)
      ST_INIT: begin
        cs1 = 1'b1;
        cs2 = 1'b1;
        case (init_idx_q)
          2'd0:    lcd_data = 8'h3F;   // display on
          2'd1:    lcd_data = 8'hC0;   // start line 0
          2'd2:    lcd_data = 8'hB8;   // page 0
          default: lcd_data = 8'h40;   // Y 0
        endcase
      end
      ST_PAGE: begin
        cs1      = ~col_q[6];
        cs2      = col_q[6];
        lcd_data = 8'hB8 | {5'd0, page_q};
      end
      ST_COL: begin
        cs1      = ~col_q[6];
        cs2      = col_q[6];
        lcd_data = 8'h40 | {2'd0, col_q[5:0]};
      end
      ST_DATA: begin
        cs1      = ~col_q[6];
        cs2      = col_q[6];
        lcd_rs   = 1'b1;
        lcd_data = data_q;
      end
      default: ;
    endcase
  end

  assign lcd_e     = in_bus && (cnt_q >= E_ON) && (cnt_q < E_OFF);
  assign lcd_rw    = 1'b0;
  assign lcd_rst_n = (state_q != ST_RST_LO);
  assign req_ready = (state_q == ST_IDLE);
  assign init_done = (state_q == ST_IDLE) || (state_q == ST_PAGE) ||
                     (state_q == ST_COL)  || (state_q == ST_DATA);

endmodule

// File: tb/tb_glcd_write_engine.sv
// -----------------------------------------------------------------------------
// tb_glcd_write_engine
//
// Self-checking bench for glcd_write_engine. A behavioural model keeps one
// address cache per half and turns each write into the list of bus words the
// panel should see; every clock is then compared against the timeline that
// list implies. Follows GLCD_ADDR_CACHE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_glcd_write_engine;

  localparam int T_SU       = 2;
  localparam int T_EH       = 4;
  localparam int T_HD       = 2;
  localparam int RST_CYCLES = 16;
  localparam int B          = T_SU + T_EH + T_HD;

  // Observed vector layout: {cs1, cs2, rs, rw, e, ready, init_done, rst_n, data}
  localparam logic [15:0] IDLE_MASK = 16'h1F00;
  localparam logic [15:0] IDLE_EXP  = 16'h0700;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_page = '0;
  logic [6:0] req_col = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, init_done, lcd_rst_n, cs1, cs2, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  glcd_write_engine #(
    .T_SU(T_SU), .T_EH(T_EH), .T_HD(T_HD), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_page(req_page), .req_col(req_col), .req_data(req_data),
    .init_done(init_done), .lcd_rst_n(lcd_rst_n),
    .cs1(cs1), .cs2(cs2), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } bus_t;

  bus_t       exp_q[$];
  logic [2:0] m_page  [2];
  int         m_col   [2];
  logic       m_valid [2];
  logic [7:0] init_w  [4] = '{8'h3F, 8'hC0, 8'hB8, 8'h40};

  function automatic logic [15:0] obs();
    return {cs1, cs2, lcd_rs, lcd_rw, lcd_e, req_ready, init_done, lcd_rst_n, lcd_data};
  endfunction

  function automatic logic [15:0] mk(input logic c1, input logic c2, input logic rs,
                                     input logic e, input logic rdy, input logic done,
                                     input logic rstn, input logic [7:0] d);
    return {c1, c2, rs, 1'b0, e, rdy, done, rstn, d};
  endfunction

  function automatic logic e_at(input int k);
    return (k >= T_SU) && (k < T_SU + T_EH);
  endfunction

  // Reference model: bus words for one write, then the cache update.
  task automatic model_request(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d);
    int  h;
    int  y;
    logic pm, cm;
    h = int'(c[6]);
    y = int'(c[5:0]);
`ifdef GLCD_ADDR_CACHE_EN
    pm = !m_valid[h] || (m_page[h] != p);
    cm = !m_valid[h] || (m_col[h] != y);
`else
    pm = 1'b1;
    cm = 1'b1;
`endif
    exp_q.delete();
    if (pm) exp_q.push_back('{rs: 1'b0, data: 8'(184 + int'(p))});
    if (cm) exp_q.push_back('{rs: 1'b0, data: 8'(64 + y)});
    exp_q.push_back('{rs: 1'b1, data: d});
    m_page[h]  = p;
    m_col[h]   = (y + 1) % 64;
    m_valid[h] = 1'b1;
  endtask

  // Entered with reset high at a negedge; releases reset and checks the
  // whole reset/init timeline up to the first idle clock.
  task automatic test_reset();
    logic [15:0] e;
    int i, k;
    checks++;
    if (obs() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs(), 16'h0000);
    end
    // A request held during init must not be taken.
    req_valid = 1'b1;
    req_page  = 3'($urandom);
    req_col   = 7'($urandom);
    req_data  = 8'($urandom);
    reset     = 1'b0;
    for (int j = 0; j <= 2 * RST_CYCLES + 4 * B; j++) begin
      if (j < RST_CYCLES) begin
        e = mk(0, 0, 0, 0, 0, 0, 0, 8'h00);
      end else if (j < 2 * RST_CYCLES) begin
        e = mk(0, 0, 0, 0, 0, 0, 1, 8'h00);
      end else if (j < 2 * RST_CYCLES + 4 * B) begin
        i = (j - 2 * RST_CYCLES) / B;
        k = (j - 2 * RST_CYCLES) % B;
        e = mk(1, 1, 0, e_at(k), 0, 0, 1, init_w[i]);
      end
      if (j < 2 * RST_CYCLES + 4 * B) begin
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL init_clk%0d: got %h expected %h", j, obs(), e);
        end
        @(negedge clk);
      end else begin
        checks++;
        if ((obs() & IDLE_MASK) !== IDLE_EXP) begin
          errors++;
          $display("FAIL init_done_clk%0d: got %h expected %h", j, obs() & IDLE_MASK, IDLE_EXP);
        end
      end
    end
    req_valid = 1'b0;
    for (int h = 0; h < 2; h++) begin
      m_page[h]  = '0;
      m_col[h]   = 0;
      m_valid[h] = 1'b1;
    end
  endtask

  // One write. If abort_col is set, reset is raised while lcd_e is high in
  // the COL cycle and the task returns after checking the reset values.
  task automatic do_request(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d,
                            input logic abort_col);
    logic [15:0] e;
    int n, abort_at;
    model_request(p, c, d);
    abort_at = -1;
    if (abort_col)
      foreach (exp_q[i])
        if (!exp_q[i].rs && exp_q[i].data[7:6] == 2'b01) abort_at = i * B + T_SU + 1;
    checks++;
    if ((obs() & IDLE_MASK) !== IDLE_EXP) begin
      errors++;
      $display("FAIL ready_before_accept: got %h expected %h", obs() & IDLE_MASK, IDLE_EXP);
    end
    req_valid = 1'b1;
    req_page  = p;
    req_col   = c;
    req_data  = d;
    @(negedge clk);
    // Scramble the inputs so the engine must use its latched copy.
    req_valid = 1'b0;
    req_page  = 3'($urandom);
    req_col   = 7'($urandom);
    req_data  = 8'($urandom);
    n = 0;
    foreach (exp_q[i]) begin
      for (int k = 0; k < B; k++) begin
        e = mk(!c[6], c[6], exp_q[i].rs, e_at(k), 0, 1, 1, exp_q[i].data);
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL bus_w%0d_clk%0d (p=%0d c=%0d): got %h expected %h", i, k, p, c, obs(), e);
        end
        if (n == abort_at) begin
          reset = 1'b1;
          @(negedge clk);
          checks++;
          if (obs() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_col: got %h expected %h", obs(), 16'h0000);
          end
          return;
        end
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if ((obs() & IDLE_MASK) !== IDLE_EXP) begin
      errors++;
      $display("FAIL ready_return (p=%0d c=%0d): got %h expected %h", p, c, obs() & IDLE_MASK, IDLE_EXP);
    end
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if ((obs() & IDLE_MASK) !== IDLE_EXP) begin
        errors++;
        $display("FAIL idle: got %h expected %h", obs() & IDLE_MASK, IDLE_EXP);
      end
    end
  endtask

  task automatic test_first_write();
    do_request(3'd2, 7'd10, 8'hFF, 1'b0);
  endtask

  task automatic test_cache_hit();
    do_request(3'd2, 7'd11, 8'h81, 1'b0);
  endtask

  task automatic test_wrap_and_halves();
    do_request(3'd2, 7'd63, 8'h01, 1'b0);
    do_request(3'd2, 7'd64, 8'h02, 1'b0);
    // cs1 column has wrapped to 0, so this write lands on the cached address.
    do_request(3'd2, 7'd0, 8'h55, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_request(3'd5, 7'd100, 8'hA5, 1'b0);
    do_request(3'd5, 7'd101, 8'h5A, 1'b0);
    do_request(3'd6, 7'd102, 8'h3C, 1'b0);
  endtask

  task automatic test_reset_mid_col();
    logic [6:0] c;
    c = {1'b0, 6'((m_col[0] + 5) % 64)};
    do_request(3'($urandom), c, 8'($urandom), 1'b1);
    @(negedge clk);
    test_reset();
  endtask

  task automatic test_random(input int count);
    int h;
    logic [2:0] p;
    logic [6:0] c;
    for (int r = 0; r < count; r++) begin
      h = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        p = m_page[h];
        c = {1'(h), 6'(m_col[h])};
      end else begin
        p = 3'($urandom);
        c = {1'(h), 6'($urandom)};
      end
      do_request(p, c, 8'($urandom), 1'b0);
      idle_gap(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_first_write();
    test_cache_hit();
    idle_gap(2);
    test_wrap_and_halves();
    test_back_to_back();
    test_reset_mid_col();
    test_first_write();
    test_cache_hit();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
